issue_nway: RTL and testbench

- In-order N-wide issue stage with an embedded shift-position scoreboard.
- Each cycle it:
  - examines the head ISSUE_WIDTH entries of the issue queue;
  - resolves each operand source (immediate, regfile, or bypass from a given pipeline stage and lane);
  - issues the longest legal in-order prefix and reports the pop count to the queue.
- Sits between the issue queue and the functional units. Replaces the fixed dual-issue stage.
- Adds configurable width, depth and memory-port count, per-stage hold, and delay-slot grouping for branches in any lane.

---
 rtl/issue_nway_pkg.sv | 30 +++
 rtl/issue_sb_nway.sv | 107 ++++++++++
 rtl/issue_nway.sv | 207 ++++++++++++++++++++
 tb/tb_issue_nway.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_nway_pkg.sv
// Shared definitions for the N-wide issue stage.
//
// Contents:
//   opsel_e      operand source selector (immediate, register file, bypass).
//   REG_ZERO     architectural zero register. It is never tracked by the scoreboard.
//   NUM_REGS     number of architectural registers.
//   onehotIndex  bit index of the set bit in a one-hot vector.
//                Returns 0 when no bit is set.
package issue_nway_pkg;

  typedef enum logic [1:0] {
    OP_IMM = 2'd0,
    OP_RF  = 2'd1,
    OP_BYP = 2'd2
  } opsel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_REGS = 32;

  // Position vectors are one-hot or zero, so the last set bit is the only set bit.
  function automatic int onehotIndex(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int k = 0; k < 32; k++) begin
      if (v[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/issue_sb_nway.sv
// Shift-position scoreboard for the N-wide issue stage.
//
// Each register 1..31 has one entry with three fields:
//   pos   one-hot pipeline position of the in-flight producer; zero means retired.
//   lane  issue lane of that producer.
//   mask  stages from which that producer's result may be bypassed.
//
// Ports:
//   i_clk, i_rst_n   clock; asynchronous active-low reset.
//   i_flash          synchronous clear of every entry. It has priority over all updates.
//   i_stage_hold     bit k set: a producer in stage k stays where it is.
//   i_wr_en          per-lane write of a newly issued producer.
//   i_wr_addr        per-lane destination register.
//   i_wr_mask        per-lane bypass mask.
//   i_rd_addr        2*ISSUE_WIDTH read addresses (operand o = 2*lane + src).
//   o_rd_pos         pos field of each read port.
//   o_rd_lane        lane field of each read port.
//   o_rd_mask        mask field of each read port.
//   Reading register 0 returns all-zero fields.
module issue_sb_nway
  import issue_nway_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 3,
  parameter int LW          = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flash,
  input  logic [DEPTH-1:0]               i_stage_hold,
  input  logic [ISSUE_WIDTH-1:0]         i_wr_en,
  input  logic [5*ISSUE_WIDTH-1:0]       i_wr_addr,
  input  logic [DEPTH*ISSUE_WIDTH-1:0]   i_wr_mask,
  input  logic [5*2*ISSUE_WIDTH-1:0]     i_rd_addr,
  output logic [DEPTH*2*ISSUE_WIDTH-1:0] o_rd_pos,
  output logic [LW*2*ISSUE_WIDTH-1:0]    o_rd_lane,
  output logic [DEPTH*2*ISSUE_WIDTH-1:0] o_rd_mask
);

  localparam int NOPS = 2 * ISSUE_WIDTH;
  localparam logic [DEPTH-1:0] TOP_POS = DEPTH'(1) << (DEPTH - 1);

  typedef struct packed {
    logic [DEPTH-1:0] pos;
    logic [LW-1:0]    lane;
    logic [DEPTH-1:0] mask;
  } sbEntry_t;

  sbEntry_t r_sb     [1:NUM_REGS-1];
  sbEntry_t w_sbNext [1:NUM_REGS-1];

  // A held stage keeps its bit.
  // A free stage k moves its bit down to k-1.
  // A bit leaving stage 0 is dropped, which retires the producer.
  function automatic logic [DEPTH-1:0] advancePos(input logic [DEPTH-1:0] pos,
                                                  input logic [DEPTH-1:0] hold);
    logic [DEPTH-1:0] nxt;
    nxt = pos & hold;
    for (int k = 1; k < DEPTH; k++) begin
      nxt[k-1] = nxt[k-1] | (pos[k] & ~hold[k]);
    end
    return nxt;
  endfunction

  // Lanes are scanned in ascending order.
  // When several lanes write the same register, the highest lane's write lands last and wins.
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      w_sbNext[r]     = r_sb[r];
      w_sbNext[r].pos = advancePos(r_sb[r].pos, i_stage_hold);
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (i_wr_en[l] && (i_wr_addr[5*l +: 5] == 5'(r))) begin
          w_sbNext[r].pos  = TOP_POS;
          w_sbNext[r].lane = LW'(l);
          w_sbNext[r].mask = i_wr_mask[DEPTH*l +: DEPTH];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) r_sb[r] <= '0;
    end else if (i_flash) begin
      for (int r = 1; r < NUM_REGS; r++) r_sb[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) r_sb[r] <= w_sbNext[r];
    end
  end

  // No entry matches address 0, so register 0 reads back as all-zero fields.
  always_comb begin
    o_rd_pos  = '0;
    o_rd_lane = '0;
    o_rd_mask = '0;
    for (int p = 0; p < NOPS; p++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (i_rd_addr[5*p +: 5] == 5'(r)) begin
          o_rd_pos[DEPTH*p +: DEPTH] = r_sb[r].pos;
          o_rd_lane[LW*p +: LW]      = r_sb[r].lane;
          o_rd_mask[DEPTH*p +: DEPTH] = r_sb[r].mask;
        end
      end
    end
  end

endmodule

// File: rtl/issue_nway.sv
// In-order N-wide issue stage with an embedded shift-position scoreboard.
//
// Each cycle the stage examines the head ISSUE_WIDTH queue entries.
// It resolves every operand as immediate, register file, or bypass.
// It then issues the longest legal in-order prefix.
//
// Ports:
//   i_clk, i_rst_n     clock; asynchronous active-low reset.
//   i_flash            pipeline flush. Clears the scoreboard; nothing issues that cycle.
//   i_stall            global issue stall. The scoreboard still advances.
//   i_stage_hold       per-stage hold. A hold on the top stage blocks issue.
//   i_iq_size          number of valid head entries.
//   i_req_*            per-lane request fields: sources, destination, bypass mask, class flags.
//   o_iq_pop_number    number of entries consumed. The issued lanes are always a prefix.
//   o_issue_valid      per-lane issue strobe.
//   o_opsel            per-operand source select (opsel_e), 2 bits each.
//   o_byp_stage        per-operand producer stage when the operand is bypassed.
//   o_byp_lane         per-operand producer lane when the operand is bypassed.
//   Operand o = 2*lane + src. Non-issued lanes drive zeros.
module issue_nway
  import issue_nway_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 3,
  parameter int MEM_PORTS   = 1,
  parameter int LW          = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1,
  parameter int CW          = $clog2(ISSUE_WIDTH + 1),
  parameter int SW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_flash,
  input  logic                           i_stall,
  input  logic [DEPTH-1:0]               i_stage_hold,
  input  logic [CW-1:0]                  i_iq_size,
  input  logic [ISSUE_WIDTH-1:0]         i_req_src1_need,
  input  logic [ISSUE_WIDTH-1:0]         i_req_src2_need,
  input  logic [5*ISSUE_WIDTH-1:0]       i_req_src1_addr,
  input  logic [5*ISSUE_WIDTH-1:0]       i_req_src2_addr,
  input  logic [ISSUE_WIDTH-1:0]         i_req_dst_need,
  input  logic [5*ISSUE_WIDTH-1:0]       i_req_dst_addr,
  input  logic [DEPTH*ISSUE_WIDTH-1:0]   i_req_accept_mask,
  input  logic [ISSUE_WIDTH-1:0]         i_req_is_branch,
  input  logic [ISSUE_WIDTH-1:0]         i_req_is_mem,
  output logic [CW-1:0]                  o_iq_pop_number,
  output logic [ISSUE_WIDTH-1:0]         o_issue_valid,
  output logic [2*2*ISSUE_WIDTH-1:0]     o_opsel,
  output logic [SW*2*ISSUE_WIDTH-1:0]    o_byp_stage,
  output logic [LW*2*ISSUE_WIDTH-1:0]    o_byp_lane
);

  localparam int NOPS = 2 * ISSUE_WIDTH;

  logic [NOPS-1:0]         w_opNeed;
  logic [5*NOPS-1:0]       w_rdAddr;
  logic [DEPTH*NOPS-1:0]   w_rdPos;
  logic [DEPTH*NOPS-1:0]   w_rdMask;
  logic [LW*NOPS-1:0]      w_rdLane;
  logic [NOPS-1:0]         w_opReady;
  opsel_e                  w_opSel   [NOPS];
  logic [SW-1:0]           w_opStage [NOPS];
  logic [LW-1:0]           w_opLane  [NOPS];
  logic [ISSUE_WIDTH-1:0]  w_laneReady;
  logic [ISSUE_WIDTH-1:0]  w_issue;
  logic [ISSUE_WIDTH-1:0]  w_wrEn;
  logic [CW-1:0]           w_popCnt;

  always_comb begin
    w_rdAddr = '0;
    w_opNeed = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_rdAddr[5*(2*i) +: 5]   = i_req_src1_addr[5*i +: 5];
      w_rdAddr[5*(2*i+1) +: 5] = i_req_src2_addr[5*i +: 5];
      w_opNeed[2*i]            = i_req_src1_need[i];
      w_opNeed[2*i+1]          = i_req_src2_need[i];
    end
  end

  // Only lanes that actually issue allocate a scoreboard entry.
  // Writes to r0 are dropped.
  always_comb begin
    w_wrEn = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_wrEn[i] = w_issue[i] && i_req_dst_need[i] && (i_req_dst_addr[5*i +: 5] != REG_ZERO);
    end
  end

  issue_sb_nway #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .DEPTH       (DEPTH),
    .LW          (LW)
  ) u_sb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flash      (i_flash),
    .i_stage_hold (i_stage_hold),
    .i_wr_en      (w_wrEn),
    .i_wr_addr    (i_req_dst_addr),
    .i_wr_mask    (i_req_accept_mask),
    .i_rd_addr    (w_rdAddr),
    .o_rd_pos     (w_rdPos),
    .o_rd_lane    (w_rdLane),
    .o_rd_mask    (w_rdMask)
  );

  // A source that names a nonzero destination of an earlier lane in the same group is not ready.
  // Results are never forwarded within a single issue cycle.
  always_comb begin
    logic [4:0]       addr;
    logic [DEPTH-1:0] pos;
    logic [DEPTH-1:0] msk;
    for (int o = 0; o < NOPS; o++) begin
      addr         = w_rdAddr[5*o +: 5];
      pos          = w_rdPos[DEPTH*o +: DEPTH];
      msk          = w_rdMask[DEPTH*o +: DEPTH];
      w_opSel[o]   = OP_IMM;
      w_opStage[o] = '0;
      w_opLane[o]  = '0;
      w_opReady[o] = 1'b1;
      if (w_opNeed[o]) begin
        if ((addr == REG_ZERO) || (pos == '0)) begin
          w_opSel[o] = OP_RF;
        end else if ((pos & msk) != '0) begin
          w_opSel[o]   = OP_BYP;
          w_opStage[o] = SW'(onehotIndex(32'(pos)));
          w_opLane[o]  = w_rdLane[LW*o +: LW];
        end else begin
          w_opReady[o] = 1'b0;
        end
        for (int j = 0; j < o / 2; j++) begin
          if (i_req_dst_need[j] && (i_req_dst_addr[5*j +: 5] != REG_ZERO) &&
              (i_req_dst_addr[5*j +: 5] == addr)) begin
            w_opReady[o] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_laneReady[i] = w_opReady[2*i] & w_opReady[2*i+1];
    end
  end

  // Grouping walks the lanes in order and stops at the first lane that cannot go.
  // A branch goes out only together with its delay slot in the next lane, and that pair ends the group.
  // A branch with no usable delay slot stays behind, so the group ends just before it.
  // nxt is clamped to a valid index; okNxt separately requires i+1 to be a real lane.
  always_comb begin
    int   memCnt;
    int   nxt;
    logic done;
    logic okCur;
    logic okNxt;
    w_issue = '0;
    memCnt  = 0;
    nxt     = 0;
    done    = 1'b0;
    okCur   = 1'b0;
    okNxt   = 1'b0;
    if (i_rst_n && !i_flash && !i_stall && !i_stage_hold[DEPTH-1]) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        nxt   = (i + 1 < ISSUE_WIDTH) ? i + 1 : i;
        okCur = (i < int'(i_iq_size)) && w_laneReady[i] &&
                (memCnt + int'(i_req_is_mem[i]) <= MEM_PORTS);
        okNxt = (i + 1 < ISSUE_WIDTH) && (nxt < int'(i_iq_size)) && w_laneReady[nxt] &&
                (memCnt + int'(i_req_is_mem[i]) + int'(i_req_is_mem[nxt]) <= MEM_PORTS);
        if (!done) begin
          if (!okCur) begin
            done = 1'b1;
          end else if (i_req_is_branch[i]) begin
            if (okNxt) begin
              w_issue[i]   = 1'b1;
              w_issue[nxt] = 1'b1;
            end
            done = 1'b1;
          end else begin
            w_issue[i] = 1'b1;
            memCnt     = memCnt + int'(i_req_is_mem[i]);
          end
        end
      end
    end
  end

  always_comb begin
    w_popCnt = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_popCnt = w_popCnt + CW'(w_issue[i]);
    end
  end

  always_comb begin
    o_opsel     = '0;
    o_byp_stage = '0;
    o_byp_lane  = '0;
    for (int o = 0; o < NOPS; o++) begin
      if (w_issue[o/2]) begin
        o_opsel[2*o +: 2]      = w_opSel[o];
        o_byp_stage[SW*o +: SW] = w_opStage[o];
        o_byp_lane[LW*o +: LW]  = w_opLane[o];
      end
    end
  end

  assign o_issue_valid   = w_issue;
  assign o_iq_pop_number = w_popCnt;

endmodule

// File: tb/tb_issue_nway.sv
// Self-checking bench for issue_nway.
//
// The reference model tracks each register's producer as a plain stage number.
// A value of -1 means the register has no producer in flight.
// The compare process checks every DUT output against the model on each falling edge.
// A directed sequence pins the model to hand-computed values.
// A randomized phase then exercises hazards, holds, stalls and flushes.
module tb_issue_nway;

  localparam int IW   = 2;
  localparam int DEPTH = 3;
  localparam int MEMP = 1;
  localparam int LW   = 1;
  localparam int CW   = 2;
  localparam int SW   = 2;
  localparam int NOPS = 2 * IW;

  typedef struct packed {
    logic             n1;
    logic [4:0]       a1;
    logic             n2;
    logic [4:0]       a2;
    logic             dn;
    logic [4:0]       d;
    logic [DEPTH-1:0] mask;
    logic             br;
    logic             mem;
  } laneReq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flash = 1'b0;
  logic stall = 1'b0;
  logic [DEPTH-1:0] stageHold = '0;
  logic [CW-1:0] iqSize = '0;
  laneReq_t req [IW];

  logic [IW-1:0]         src1Need, src2Need, dstNeed, isBranch, isMem;
  logic [5*IW-1:0]       src1Addr, src2Addr, dstAddr;
  logic [DEPTH*IW-1:0]   acceptMask;
  logic [CW-1:0]         popNumber;
  logic [IW-1:0]         issueValid;
  logic [2*NOPS-1:0]     opsel;
  logic [SW*NOPS-1:0]    bypStage;
  logic [LW*NOPS-1:0]    bypLane;

  int nTests = 0;
  int nFail = 0;

  // Model state: producer stage per register (-1 = none), its lane and bypass mask.
  int               mStage [32];
  int               mLane  [32];
  logic [DEPTH-1:0] mMask  [32];
  int               expCount = 0;

  always #5 clk = ~clk;

  always_comb begin
    src1Need = '0; src2Need = '0; dstNeed = '0; isBranch = '0; isMem = '0;
    src1Addr = '0; src2Addr = '0; dstAddr = '0; acceptMask = '0;
    for (int i = 0; i < IW; i++) begin
      src1Need[i] = req[i].n1;
      src2Need[i] = req[i].n2;
      dstNeed[i] = req[i].dn;
      isBranch[i] = req[i].br;
      isMem[i] = req[i].mem;
      src1Addr[5*i +: 5] = req[i].a1;
      src2Addr[5*i +: 5] = req[i].a2;
      dstAddr[5*i +: 5] = req[i].d;
      acceptMask[DEPTH*i +: DEPTH] = req[i].mask;
    end
  end

  issue_nway #(
    .ISSUE_WIDTH (IW),
    .DEPTH       (DEPTH),
    .MEM_PORTS   (MEMP)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_flash           (flash),
    .i_stall           (stall),
    .i_stage_hold      (stageHold),
    .i_iq_size         (iqSize),
    .i_req_src1_need   (src1Need),
    .i_req_src2_need   (src2Need),
    .i_req_src1_addr   (src1Addr),
    .i_req_src2_addr   (src2Addr),
    .i_req_dst_need    (dstNeed),
    .i_req_dst_addr    (dstAddr),
    .i_req_accept_mask (acceptMask),
    .i_req_is_branch   (isBranch),
    .i_req_is_mem      (isMem),
    .o_iq_pop_number   (popNumber),
    .o_issue_valid     (issueValid),
    .o_opsel           (opsel),
    .o_byp_stage       (bypStage),
    .o_byp_lane        (bypLane)
  );

  // One comparison: counts it, and prints a FAIL line when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of one cycle's outputs, built directly from the issue rules.
  // Each operand is classified from its register's producer stage and mask.
  // The model then counts how many head lanes may go in order.
  function automatic void modelCompute(output int cnt, output logic [2*NOPS-1:0] sel,
                                       output logic [SW*NOPS-1:0] stg,
                                       output logic [LW*NOPS-1:0] ln);
    int  opKind [NOPS];
    int  opStg  [NOPS];
    int  opLn   [NOPS];
    bit  rdy    [IW];
    int  mem;
    int  i;
    bit  blocked;
    for (int l = 0; l < IW; l++) begin
      rdy[l] = 1;
      for (int s = 0; s < 2; s++) begin
        int  o;
        bit  need;
        int  a;
        o = 2*l + s;
        need = (s == 0) ? req[l].n1 : req[l].n2;
        a = (s == 0) ? int'(req[l].a1) : int'(req[l].a2);
        opKind[o] = 0; opStg[o] = 0; opLn[o] = 0;
        if (need) begin
          if (a == 0 || mStage[a] < 0) opKind[o] = 1;
          else if (mMask[a][mStage[a]]) begin
            opKind[o] = 2; opStg[o] = mStage[a]; opLn[o] = mLane[a];
          end else rdy[l] = 0;
          for (int j = 0; j < l; j++)
            if (req[j].dn && req[j].d != 0 && int'(req[j].d) == a) rdy[l] = 0;
        end
      end
    end
    blocked = !rst_n || flash || stall || stageHold[DEPTH-1];
    cnt = 0; mem = 0; i = 0;
    while (!blocked && i < IW) begin
      if (!(i < int'(iqSize) && rdy[i] && mem + int'(req[i].mem) <= MEMP)) break;
      if (req[i].br) begin
        if (i + 1 < IW && i + 1 < int'(iqSize) && rdy[i+1] &&
            mem + int'(req[i].mem) + int'(req[i+1].mem) <= MEMP)
          cnt = i + 2;
        break;
      end
      mem += int'(req[i].mem);
      i++;
      cnt = i;
    end
    sel = '0; stg = '0; ln = '0;
    for (int o = 0; o < 2*cnt; o++) begin
      sel[2*o +: 2] = 2'(opKind[o]);
      stg[SW*o +: SW] = SW'(opStg[o]);
      ln[LW*o +: LW] = LW'(opLn[o]);
    end
  endfunction

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    int cnt;
    logic [2*NOPS-1:0] sel;
    logic [SW*NOPS-1:0] stg;
    logic [LW*NOPS-1:0] ln;
    modelCompute(cnt, sel, stg, ln);
    expCount = cnt;
    checkOutput("model pop", 32'(popNumber), 32'(cnt));
    checkOutput("model valid", 32'(issueValid), 32'((1 << cnt) - 1));
    checkOutput("model opsel", 32'(opsel), 32'(sel));
    checkOutput("model byp_stage", 32'(bypStage), 32'(stg));
    checkOutput("model byp_lane", 32'(bypLane), 32'(ln));
  end

  // Model state update at the clock edge.
  // Producers step down one stage unless held.
  // Then the issued lanes claim their destinations in lane order, so the highest lane wins.
  always @(posedge clk) begin
    if (!rst_n || flash) begin
      for (int r = 0; r < 32; r++) mStage[r] = -1;
    end else begin
      for (int r = 1; r < 32; r++)
        if (mStage[r] >= 0 && !stageHold[mStage[r]]) mStage[r] = mStage[r] - 1;
      for (int l = 0; l < expCount; l++) begin
        if (req[l].dn && req[l].d != 0) begin
          mStage[req[l].d] = DEPTH - 1;
          mLane[req[l].d] = l;
          mMask[req[l].d] = req[l].mask;
        end
      end
    end
  end

  function automatic laneReq_t mkReq(input bit n1, input int a1, input bit n2, input int a2,
                                     input bit dn, input int d, input int mask,
                                     input bit br, input bit mem);
    laneReq_t q;
    q.n1 = n1; q.a1 = 5'(a1); q.n2 = n2; q.a2 = 5'(a2);
    q.dn = dn; q.d = 5'(d); q.mask = DEPTH'(mask); q.br = br; q.mem = mem;
    return q;
  endfunction

  // Drives one cycle's request: queue size plus both lanes.
  task automatic applyStimulus(input int size, input laneReq_t l0, input laneReq_t l1);
    iqSize = CW'(size);
    req[0] = l0;
    req[1] = l1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  laneReq_t NOP;

  initial begin
    for (int r = 0; r < 32; r++) begin mStage[r] = -1; mLane[r] = 0; mMask[r] = '0; end
    NOP = mkReq(0, 0, 0, 0, 0, 0, 0, 0, 0);
    req[0] = NOP; req[1] = NOP;

    // Reset: everything quiet
    applyStimulus(2, mkReq(1, 1, 1, 2, 1, 3, 2, 0, 0), NOP);
    @(negedge clk);
    checkOutput("reset pop", 32'(popNumber), 0);
    checkOutput("reset valid", 32'(issueValid), 0);
    checkOutput("reset opsel", 32'(opsel), 0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    // Two independent adds issue together
    applyStimulus(2, mkReq(1, 1, 1, 2, 1, 3, 'b010, 0, 0), mkReq(1, 5, 0, 0, 1, 4, 'b010, 0, 0));
    @(negedge clk);
    checkOutput("dual valid", 32'(issueValid), 32'h3);
    checkOutput("dual pop", 32'(popNumber), 2);
    checkOutput("dual opsel", 32'(opsel), 32'h15);
    nextCycle();

    // r3 sits in the top stage, whose result is not bypassable yet
    applyStimulus(1, mkReq(1, 3, 0, 0, 0, 0, 0, 0, 0), NOP);
    @(negedge clk);
    checkOutput("r3 top pop", 32'(popNumber), 0);
    nextCycle();

    // r3 and r4 both in stage 1 now, bypassed from lanes 0 and 1
    applyStimulus(2, mkReq(1, 3, 0, 0, 0, 0, 0, 0, 0), mkReq(1, 4, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("byp pop", 32'(popNumber), 2);
    checkOutput("byp opsel", 32'(opsel), 32'h22);
    checkOutput("byp stage", 32'(bypStage), 32'h11);
    checkOutput("byp lane", 32'(bypLane), 32'h4);
    nextCycle();

    // Intra-group RAW: lane1 reads lane0's destination
    applyStimulus(2, mkReq(1, 1, 0, 0, 1, 10, 0, 0, 0), mkReq(1, 10, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("raw valid", 32'(issueValid), 32'h1);
    checkOutput("raw pop", 32'(popNumber), 1);
    nextCycle();

    // Branch in the last lane has no delay slot
    applyStimulus(2, NOP, mkReq(0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    checkOutput("br lane1 pop", 32'(popNumber), 1);
    nextCycle();

    applyStimulus(2, mkReq(0, 0, 0, 0, 0, 0, 0, 1, 0), NOP);
    @(negedge clk);
    checkOutput("br lane0 pop", 32'(popNumber), 2);
    nextCycle();

    applyStimulus(1, mkReq(0, 0, 0, 0, 0, 0, 0, 1, 0), NOP);
    @(negedge clk);
    checkOutput("br size1 pop", 32'(popNumber), 0);
    nextCycle();

    // Hold on the top stage keeps r3 there; stall still lets it advance
    applyStimulus(1, mkReq(0, 0, 0, 0, 1, 3, 'b010, 0, 0), NOP);
    @(negedge clk);
    checkOutput("r3 write pop", 32'(popNumber), 1);
    nextCycle();
    stageHold = 3'b100;
    applyStimulus(1, mkReq(1, 3, 0, 0, 0, 0, 0, 0, 0), NOP);
    @(negedge clk);
    checkOutput("hold pop", 32'(popNumber), 0);
    nextCycle();
    stageHold = 3'b000;
    stall = 1'b1;
    @(negedge clk);
    checkOutput("stall pop", 32'(popNumber), 0);
    nextCycle();
    stall = 1'b0;
    @(negedge clk);
    checkOutput("after stall pop", 32'(popNumber), 1);
    checkOutput("after stall opsel", 32'(opsel), 32'h2);
    checkOutput("after stall stage", 32'(bypStage), 32'h1);
    nextCycle();

    // Two memory ops against one port
    applyStimulus(2, mkReq(0, 0, 0, 0, 0, 0, 0, 0, 1), mkReq(0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    checkOutput("mem pop", 32'(popNumber), 1);
    nextCycle();

    // Flush clears r20, so the dependent op afterwards reads the register file
    applyStimulus(1, mkReq(0, 0, 0, 0, 1, 20, 0, 0, 0), NOP);
    nextCycle();
    flash = 1'b1;
    applyStimulus(1, NOP, NOP);
    @(negedge clk);
    checkOutput("flash pop", 32'(popNumber), 0);
    nextCycle();
    flash = 1'b0;
    applyStimulus(1, mkReq(1, 20, 0, 0, 0, 0, 0, 0, 0), NOP);
    @(negedge clk);
    checkOutput("post flash pop", 32'(popNumber), 1);
    checkOutput("post flash opsel", 32'(opsel), 32'h1);
    nextCycle();

    // Randomized phase over a small register window so hazards are frequent
    for (int c = 0; c < 3000; c++) begin
      laneReq_t q [IW];
      for (int l = 0; l < IW; l++) begin
        q[l] = mkReq($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 2) == 0));
      end
      flash = ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < DEPTH; k++) stageHold[k] = ($urandom_range(0, 5) == 0);
      applyStimulus($urandom_range(0, 3), q[0], q[1]);
      nextCycle();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
